demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits.
REQ-002 Parameter SNUM, default 2, select width; channel count N = 2**SNUM.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i  input  WIDTH  input data word.
REQ-006 sel  input  SNUM  destination channel index, sampled with i.
REQ-007 bcast  input  1  1 = broadcast the word to all N channels; sel is ignored.
REQ-008 i_valid  input  1  input word present.
REQ-009 i_ready  output  1  block accepts the word this cycle.
REQ-010 o  output  N*WIDTH  per-channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 o_valid  output  N  per-channel word present.
REQ-012 o_ready  input  N  per-channel downstream accept.
REQ-013 o_cnt  output  N*8  per-channel delivered-word counter; channel k occupies bits [k*8 +: 8].

Function
REQ-014 Input transfer occurs on a cycle with i_valid and i_ready both high; output transfer on channel k occurs on a cycle with o_valid[k] and o_ready[k] both high.
REQ-015 Each channel has a one-entry holding register (slot); a slot is "free" if it is empty, or if it is full and o_ready[k] is high this cycle.
REQ-016 bcast=0: i_ready = slot[sel] free; no combinational dependence on other channels.
REQ-017 bcast=1: i_ready = all N slots free; an accepted word loads every slot in the same cycle.
REQ-018 Latency: a word accepted at edge t drives o_valid[k]=1 and o (channel k) = that word from edge t to the edge at which it is transferred out.
REQ-019 While o_valid[k]=1 and o_ready[k]=0, channel k data and o_valid[k] hold stable.
REQ-020 Same-cycle drain and refill of one slot is allowed; sustained throughput is 1 word/cycle per channel.
REQ-021 i_ready may depend combinationally on o_ready, sel and bcast; o_valid and o are register outputs only.
REQ-022 Channels are independent: back-pressure on channel j never stalls a bcast=0 transfer to channel k != j.
REQ-023 o_cnt[k] increments by 1 on each channel-k output transfer and wraps 255 -> 0 without saturation.
REQ-024 A slot not selected this cycle keeps its contents unchanged.
REQ-025 Words are delivered in acceptance order per channel; no word is dropped or duplicated, except the intentional copies made by broadcast.

Reset
REQ-026 While rst_n=0: all o_valid = 0, all o = 0, all o_cnt = 0, i_ready = 0.
REQ-027 Reset asserted mid-transfer discards all slot contents immediately, without waiting for a clock edge.
REQ-028 The first acceptance is permitted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package demux_stream_pkg holds the N = 2**SNUM derivation, the count width constant (8), and the default WIDTH/SNUM values.
REQ-030 The per-channel slot plus counter is the sub-module demux_out_slot, instantiated N times with a generate loop.
REQ-031 The top level contains only the select decode, the i_ready logic and the generate loop; its target size is 120-400 RTL lines in total.

Verification
REQ-032 Route: WIDTH=8, SNUM=2, all o_ready=1; send A0 to sel=0, B1 to sel=1, C2 to sel=2, D3 to sel=3 on consecutive cycles -> each appears on its channel 1 cycle later, i_ready stays 1, and each o_cnt = 1.
REQ-033 Back-pressure: o_ready[1]=0; send 11 then 22 to sel=1 -> 11 holds on channel 1, i_ready drops for the second word; meanwhile 33 to sel=2 is accepted; after o_ready[1]=1, 22 follows 11.
REQ-034 Broadcast: bcast=1, i=5A, o_ready[3]=0 with slot 3 full -> i_ready=0; release o_ready[3] -> 5A is loaded into all 4 slots in one cycle.
REQ-035 Full throughput: channel 0 with o_ready=1 continuously and 300 back-to-back words -> no bubbles, and o_cnt[0] wraps to 44 (300 mod 256).
REQ-036 Reset mid-operation: slots full with data, pull rst_n low between edges -> o_valid=0 and o=0 immediately; after release the first new word is delivered correctly.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared constants for the stream demultiplexer.
//   DEF_WIDTH / DEF_SNUM : default data and select widths
//   CNT_W                : width of each per-channel delivered-word counter
//   num_ch()             : channel count N = 2**SNUM
package demux_stream_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SNUM  = 2;
  localparam int CNT_W     = 8;

  function automatic int num_ch(input int snum);
    return 2 ** snum;
  endfunction
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one output channel -- a single-entry holding register plus
// a wrapping count of words handed downstream.
//   clk, rst_n : clock, async active-low reset
//   load, d    : write d into the slot this cycle (only asserted when free)
//   o_ready    : downstream accept
//   free       : slot can take a word this cycle (empty, or draining now)
//   o, o_valid : registered channel output
//   o_cnt      : delivered-word counter, wraps 255 -> 0
module demux_out_slot
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             o_ready,
  output logic             free,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_cnt
);
  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             xfer;

  assign xfer = vld_q & o_ready;
  assign free = ~vld_q | o_ready;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (xfer) begin
      vld_d = 1'b0;
      cnt_d = cnt_q + 1'b1;
    end
    // Load wins over drain so a slot can drain and refill in one cycle.
    if (load) begin
      vld_d  = 1'b1;
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o       = data_q;
  assign o_valid = vld_q;
  assign o_cnt   = cnt_q;
endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes an input stream to one of N = 2**SNUM registered
// output channels, or to all channels at once when bcast is set.
//   clk, rst_n          : clock, async active-low reset
//   i, sel, bcast       : input word, destination index, broadcast request
//   i_valid / i_ready   : input handshake
//   o, o_valid, o_ready : per-channel output streams, channel k at [k*WIDTH +: WIDTH]
//   o_cnt               : per-channel delivered-word counters, channel k at [k*8 +: 8]
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SNUM  = DEF_SNUM,
  localparam int N    = num_ch(SNUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i,
  input  logic [SNUM-1:0]    sel,
  input  logic               bcast,
  input  logic               i_valid,
  output logic               i_ready,
  output logic [N*WIDTH-1:0] o,
  output logic [N-1:0]       o_valid,
  input  logic [N-1:0]       o_ready,
  output logic [N*CNT_W-1:0] o_cnt
);
  logic [N-1:0] free;
  logic [N-1:0] sel_dec;
  logic [N-1:0] load;
  logic         accept;

  always_comb begin
    sel_dec = '0;
    sel_dec[sel] = 1'b1;
  end

  // Unicast only looks at the selected slot, so a stalled channel never
  // blocks traffic to the others. Gated by rst_n because empty slots
  // report free while reset holds them.
  assign i_ready = rst_n & (bcast ? (&free) : free[sel]);
  assign accept  = i_valid & i_ready;
  assign load    = {N{accept}} & (bcast ? {N{1'b1}} : sel_dec);

  for (genvar k = 0; k < N; k++) begin : g_ch
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .d       (i),
      .o_ready (o_ready[k]),
      .free    (free[k]),
      .o       (o[k*WIDTH +: WIDTH]),
      .o_valid (o_valid[k]),
      .o_cnt   (o_cnt[k*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i;
  logic [1:0]  sel;
  logic        bcast;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] o;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
  logic [31:0] o_cnt;

  int nchk = 0;
  int nerr = 0;

  demux_stream #(.WIDTH(8), .SNUM(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .sel     (sel),
    .bcast   (bcast),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_cnt   (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [7:0] d);
    i_valid = v; sel = s; bcast = b; i = d;
  endtask

  initial begin
    int bub, bad;
    rst_n = 1'b0; o_ready = 4'hF;
    drive(1'b1, 2'd0, 1'b0, 8'hEE);
    cyc(); cyc();
    #1;
    chk("rst_o_valid", o_valid, 4'h0);
    chk("rst_o", o, 32'h0);
    chk("rst_o_cnt", o_cnt, 32'h0);
    chk("rst_i_ready", i_ready, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Route: one word per channel on consecutive cycles
    drive(1'b1, 2'd0, 1'b0, 8'hA0); #1; chk("route_rdy0", i_ready, 1'b1);
    cyc(); chk("route_v0", o_valid, 4'b0001); chk("route_d0", o[7:0], 8'hA0);
    drive(1'b1, 2'd1, 1'b0, 8'hB1); #1; chk("route_rdy1", i_ready, 1'b1);
    cyc(); chk("route_v1", o_valid, 4'b0010); chk("route_d1", o[15:8], 8'hB1);
    drive(1'b1, 2'd2, 1'b0, 8'hC2); #1; chk("route_rdy2", i_ready, 1'b1);
    cyc(); chk("route_v2", o_valid, 4'b0100); chk("route_d2", o[23:16], 8'hC2);
    drive(1'b1, 2'd3, 1'b0, 8'hD3); #1; chk("route_rdy3", i_ready, 1'b1);
    cyc(); chk("route_v3", o_valid, 4'b1000); chk("route_d3", o[31:24], 8'hD3);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cyc(); chk("route_cnt", o_cnt, 32'h01010101); chk("route_idle", o_valid, 4'h0);

    // Back-pressure on channel 1
    o_ready = 4'b1101;
    drive(1'b1, 2'd1, 1'b0, 8'h11); #1; chk("bp_rdy11", i_ready, 1'b1);
    cyc(); chk("bp_v11", o_valid, 4'b0010); chk("bp_d11", o[15:8], 8'h11);
    drive(1'b1, 2'd1, 1'b0, 8'h22); #1; chk("bp_rdy22_blk", i_ready, 1'b0);
    cyc(); chk("bp_hold11", o[15:8], 8'h11); chk("bp_hold_v", o_valid, 4'b0010);
    drive(1'b1, 2'd2, 1'b0, 8'h33); #1; chk("bp_rdy33", i_ready, 1'b1);
    cyc(); chk("bp_v33", o_valid, 4'b0110); chk("bp_d33", o[23:16], 8'h33);
    chk("bp_still11", o[15:8], 8'h11);
    o_ready = 4'hF;
    drive(1'b1, 2'd1, 1'b0, 8'h22); #1; chk("bp_rdy22", i_ready, 1'b1);
    cyc(); chk("bp_v22", o_valid, 4'b0010); chk("bp_d22", o[15:8], 8'h22);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cyc(); chk("bp_cnt", o_cnt, 32'h01020301);

    // Broadcast blocked by a full, stalled slot 3
    o_ready = 4'b0111;
    drive(1'b1, 2'd3, 1'b0, 8'h77);
    cyc(); chk("bc_fill3", o_valid, 4'b1000);
    drive(1'b1, 2'd0, 1'b1, 8'h5A); #1; chk("bc_rdy_blk", i_ready, 1'b0);
    cyc(); chk("bc_hold_v", o_valid, 4'b1000); chk("bc_hold_d", o[31:24], 8'h77);
    o_ready = 4'hF; #1; chk("bc_rdy", i_ready, 1'b1);
    cyc(); chk("bc_v", o_valid, 4'hF); chk("bc_d", o, 32'h5A5A5A5A);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cyc(); chk("bc_cnt", o_cnt, 32'h03030402);

    // Reset between edges with all slots full
    o_ready = 4'h0;
    drive(1'b1, 2'd0, 1'b1, 8'h3C);
    cyc(); chk("mr_full", o_valid, 4'hF);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_v", o_valid, 4'h0); chk("mr_o", o, 32'h0);
    chk("mr_cnt", o_cnt, 32'h0); chk("mr_rdy", i_ready, 1'b0);
    cyc();
    rst_n = 1'b1; o_ready = 4'hF;
    drive(1'b1, 2'd2, 1'b0, 8'h96); #1; chk("mr_rdy_first", i_ready, 1'b1);
    cyc(); chk("mr_first_v", o_valid, 4'b0100); chk("mr_first_d", o[23:16], 8'h96);
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cyc();

    // 300 back-to-back words on channel 0
    bub = 0; bad = 0;
    for (int n = 0; n < 300; n++) begin
      drive(1'b1, 2'd0, 1'b0, n[7:0]); #1;
      if (i_ready !== 1'b1) bub++;
      cyc();
      if (o_valid[0] !== 1'b1 || o[7:0] !== n[7:0]) bad++;
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00);
    cyc();
    chk("tp_bubbles", bub, 0);
    chk("tp_data", bad, 0);
    chk("tp_cnt0", o_cnt[7:0], 8'd44);
    chk("tp_cnt2", o_cnt[23:16], 8'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
